stream_max_2b: RTL and testbench
================================

STREAM_MAX_2B -- requirements
Module: stream_max_2b

Interface
REQ-001 Parameter N, default 2: data width; fixed by the downstream comparator, only 2 is supported.
REQ-002 Parameter IW, default 4: beat-index width; maximum frame position 2**IW-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_data  input  N  input beat value.
REQ-007 in_last  input  1  marks final beat of a frame.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 out_valid  output  1  frame result present.
REQ-010 out_max  output  N  largest value in the frame.
REQ-011 out_idx  output  IW  position of the first occurrence of out_max, first beat = 0.
REQ-012 out_ovf  output  1  frame was longer than 2**IW beats.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready, combinationally.
REQ-016 States: ACCUM (frame open or empty) and HOLD (result held); reset state is ACCUM with no frame open.
REQ-017 First beat of a frame: loads running max := in_data, max_idx := 0, position counter := 1, ovf := 0.
REQ-018 Later beat: comparator computes gt = (in_data > running max), unsigned; if gt, running max := in_data and max_idx := current position; ties keep the earlier index.
REQ-019 Position counter increments per accepted beat; on wrap from 2**IW-1 to 0 it SHALL set ovf, and ovf stays set until the frame ends.
REQ-020 Beats accepted after ovf is set still update the max; max_idx takes the wrapped position value.
REQ-021 Beat with in_last: the final max/idx/ovf, including that beat's own comparison, are registered to out_*; out_valid rises the next cycle; state goes to HOLD; no frame is open.
REQ-022 Single-beat frame (first beat has in_last): out_max = in_data, out_idx = 0, out_ovf = 0.
REQ-023 In HOLD, out_* SHALL stay stable until the output transfer.
REQ-024 Same-cycle output transfer and input transfer: the result is released and the beat is processed as the first beat of the next frame.
REQ-025 Same-cycle output transfer and in_last on a first beat: out_valid stays 1 and out_* reload with the new single-beat result.
REQ-026 Latency: last beat accepted in cycle k gives out_valid = 1 in cycle k+1; throughput is one beat per cycle while out_ready = 1.
REQ-027 in_data and in_last are ignored when no input transfer occurs.

Reset
REQ-028 On rst_n low, asynchronously: out_valid = 0, out_max = 0, out_idx = 0, out_ovf = 0, running max = 0, position = 0, frame-open flag = 0, state = ACCUM.
REQ-029 Reset mid-frame discards the partial frame; the first accepted beat after reset starts a new frame.
REQ-030 in_ready during reset follows REQ-015, so it reads 1.

Structure
REQ-031 A shared package stream_max_pkg SHALL hold the state enum (ACCUM, HOLD) and the default values of N and IW.
REQ-032 Exactly one sub-module, the existing greater_than_2b comparator, with ports a = in_data and b = running max; its gt output drives the update.
REQ-033 No other arithmetic comparison in the block.

Verification
REQ-034 Frame 1,3,2 (last on 2), out_ready = 1 -> cycle after last: out_valid = 1, out_max = 3, out_idx = 1, out_ovf = 0.
REQ-035 Frame 2,3,3,1 -> out_max = 3, out_idx = 1 (tie keeps first).
REQ-036 Single beat 0 with last, out_ready = 0 for 5 cycles -> out_max = 0, out_idx = 0 held stable; in_ready = 0 throughout; result transfers when out_ready rises.
REQ-037 IW = 2, frame of 6 beats 0,0,0,0,0,3 -> out_ovf = 1, out_max = 3, out_idx = 1 (wrapped position).
REQ-038 Back-to-back frames {1 last} and {2 last}, out_ready = 1 -> consecutive results 1 then 2; no bubble; in_ready stays 1.
REQ-039 rst_n pulsed low after 2 beats of a frame -> out_valid = 0 immediately; next frame 2,1 last -> out_max = 2, out_idx = 0.

Source files
------------

// File: rtl/stream_max_pkg.sv
// -----------------------------------------------------------------------------
// stream_max_pkg
//   Shared definitions for the stream_max_2b frame-maximum block.
//   - N_DEFAULT  : data width. The downstream comparator is 2 bits wide, so
//                  2 is the only supported value.
//   - IW_DEFAULT : beat-index width. The largest frame position is 2**IW-1.
//   - state_t    : control state. ACCUM means a frame is open or nothing is
//                  held. HOLD means a finished result is waiting for the
//                  consumer.
// -----------------------------------------------------------------------------
package stream_max_pkg;

  localparam int N_DEFAULT  = 2;
  localparam int IW_DEFAULT = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage : stream_max_pkg

// File: rtl/greater_than_2b.sv
// -----------------------------------------------------------------------------
// greater_than_2b
//   Unsigned 2-bit magnitude comparator, built from plain gates.
//   Ports:
//     a  [1:0] in  : candidate value
//     b  [1:0] in  : reference value
//     gt       out : 1 when a > b (unsigned)
// -----------------------------------------------------------------------------
module greater_than_2b (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt
);

  logic w_msb_gt;
  logic w_msb_eq;
  logic w_lsb_gt;

  // The MSB decides unless the two MSBs are equal. In that case the LSB decides.
  assign w_msb_gt = a[1] & ~b[1];
  assign w_msb_eq = ~(a[1] ^ b[1]);
  assign w_lsb_gt = a[0] & ~b[0];
  assign gt       = w_msb_gt | (w_msb_eq & w_lsb_gt);

endmodule : greater_than_2b

// File: rtl/stream_max_2b.sv
// -----------------------------------------------------------------------------
// stream_max_2b
//   Finds the largest value in each frame of a valid/ready beat stream. For
//   each frame it reports that value, the position of its first occurrence
//   and whether the frame overran the position counter.
//
//   Parameters:
//     N   data width. Only 2 is supported, because the comparator is fixed.
//     IW  beat-index width. Positions wrap modulo 2**IW.
//   Ports:
//     clk        in      rising-edge clock
//     rst_n      in      asynchronous active-low reset
//     in_valid   in      input beat present
//     in_data    in  N   input beat value
//     in_last    in      final beat of the frame
//     in_ready   out     beat accepted this cycle (= !out_valid || out_ready)
//     out_valid  out     frame result present
//     out_max    out N   largest value in the frame
//     out_idx    out IW  position of the first occurrence of out_max
//     out_ovf    out     frame was longer than 2**IW beats
//     out_ready  in      consumer accepts the result
// -----------------------------------------------------------------------------
module stream_max_2b
  import stream_max_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_max,
  output logic [IW-1:0] out_idx,
  output logic          out_ovf,
  input  logic          out_ready
);

  // Control state
  state_t        r_state;
  state_t        w_state_nxt;

  // Running frame state
  logic          r_open;      // a frame has started and has not yet seen in_last
  logic [N-1:0]  r_max;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_pos;       // position of the next beat
  logic          r_ovf;

  // Held result
  logic [N-1:0]  r_out_max;
  logic [IW-1:0] r_out_idx;
  logic          r_out_ovf;

  // Combinational helpers
  logic          w_xfer_in;
  logic          w_xfer_out;
  logic          w_gt;
  logic          w_pos_carry;
  logic [IW-1:0] w_pos_inc;
  logic [N-1:0]  w_beat_max;  // max including the current beat
  logic [IW-1:0] w_beat_idx;  // index including the current beat
  logic          w_beat_ovf;  // ovf as seen by the current beat
  logic          w_ovf_nxt;   // ovf carried to the next beat
  logic [IW-1:0] w_pos_nxt;

  // Handshake
  assign out_valid  = (r_state == HOLD);
  assign in_ready   = !out_valid || out_ready;
  assign w_xfer_in  = in_valid && in_ready;
  assign w_xfer_out = out_valid && out_ready;

  assign out_max = r_out_max;
  assign out_idx = r_out_idx;
  assign out_ovf = r_out_ovf;

  // The carry out of the increment flags the wrap from 2**IW-1 to 0. This
  // avoids needing a second comparator.
  assign {w_pos_carry, w_pos_inc} = {1'b0, r_pos} + {{IW{1'b0}}, 1'b1};

  greater_than_2b u_gt (
    .a  (in_data),
    .b  (r_max),
    .gt (w_gt)
  );

  // Per-beat update. A beat that arrives with no frame open starts a new frame.
  // The ovf flag reported with a beat is the one raised by earlier wraps.
  // A frame of exactly 2**IW beats wraps only on its own last beat, so it does
  // not report an overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path
    // leaves a variable unassigned and infers a latch.
    w_beat_max = in_data;
    w_beat_idx = '0;
    w_beat_ovf = 1'b0;
    w_ovf_nxt  = 1'b0;
    w_pos_nxt  = IW'(1);
    if (r_open) begin
      // Only a strictly greater value replaces the max, so ties keep the earlier index.
      w_beat_max = w_gt ? in_data : r_max;
      w_beat_idx = w_gt ? r_pos   : r_idx;
      w_beat_ovf = r_ovf;
      w_ovf_nxt  = r_ovf | w_pos_carry;
      w_pos_nxt  = w_pos_inc;
    end
  end

  // Next-state logic. In HOLD an accepted beat implies out_ready, so the held
  // result is always released in the same cycle. A last beat then reloads it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: begin
        if (w_xfer_in && in_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (w_xfer_out && !(w_xfer_in && in_last)) begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open    <= 1'b0;
      r_max     <= '0;
      r_idx     <= '0;
      r_pos     <= '0;
      r_ovf     <= 1'b0;
      r_out_max <= '0;
      r_out_idx <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_xfer_in) begin
      if (in_last) begin
        // Close the frame. The running registers go stale, but r_open = 0
        // makes the next beat reload them.
        r_open    <= 1'b0;
        r_out_max <= w_beat_max;
        r_out_idx <= w_beat_idx;
        r_out_ovf <= w_beat_ovf;
      end else begin
        r_open <= 1'b1;
        r_max  <= w_beat_max;
        r_idx  <= w_beat_idx;
        r_ovf  <= w_ovf_nxt;
        r_pos  <= w_pos_nxt;
      end
    end
  end

endmodule : stream_max_2b

// File: tb/tb_stream_max_2b.sv
// -----------------------------------------------------------------------------
// tb_stream_max_2b
//   Two instances of the block share the same stimulus: one with the default
//   IW = 4 and one with IW = 2. Expected results come from a frame-level model.
//   The model stores each accepted frame and scans it for the maximum and its
//   first occurrence. The index is that occurrence's position modulo 2**IW, and
//   ovf is set when the frame length exceeds 2**IW.
// -----------------------------------------------------------------------------
module tb_stream_max_2b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready4, out_valid4, out_ovf4;
  logic [1:0] out_max4;
  logic [3:0] out_idx4;
  logic       in_ready2, out_valid2, out_ovf2;
  logic [1:0] out_max2;
  logic [1:0] out_idx2;

  always #5 clk = ~clk;

  stream_max_2b dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_max   (out_max4),
    .out_idx   (out_idx4),
    .out_ovf   (out_ovf4),
    .out_ready (out_ready)
  );

  stream_max_2b #(.N(2), .IW(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready2),
    .out_valid (out_valid2),
    .out_max   (out_max2),
    .out_idx   (out_idx2),
    .out_ovf   (out_ovf2),
    .out_ready (out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level reference model
  int frame_q[$];
  bit m_valid;
  int m_max, m_idx4, m_ovf4, m_idx2, m_ovf2;
  bit last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_valid = 1'b0;
  endtask

  task automatic model_close_frame();
    int mx;
    int first;
    mx    = -1;
    first = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i] > mx) begin
        mx    = frame_q[i];
        first = i;
      end
    end
    m_max  = mx;
    m_idx4 = first % 16;
    m_idx2 = first % 4;
    m_ovf4 = (frame_q.size() > 16) ? 1 : 0;
    m_ovf2 = (frame_q.size() > 4) ? 1 : 0;
    m_valid = 1'b1;
    frame_q.delete();
  endtask

  // One clock cycle. The task drives the inputs on the falling edge and checks
  // the outputs 1 time unit later. It then steps the model and returns just
  // after the rising edge.
  task automatic dc(input bit v, input int d, input bit l, input bit ordy);
    bit exp_ready;
    bit xin;
    bit xout;
    @(negedge clk);
    in_valid  = v;
    in_data   = d[1:0];
    in_last   = l;
    out_ready = ordy;
    #1;
    exp_ready = !m_valid || ordy;
    check("in_ready4", in_ready4, exp_ready);
    check("in_ready2", in_ready2, exp_ready);
    check("out_valid4", out_valid4, m_valid);
    check("out_valid2", out_valid2, m_valid);
    if (m_valid) begin
      check("out_max4", out_max4, m_max);
      check("out_idx4", out_idx4, m_idx4);
      check("out_ovf4", out_ovf4, m_ovf4);
      check("out_max2", out_max2, m_max);
      check("out_idx2", out_idx2, m_idx2);
      check("out_ovf2", out_ovf2, m_ovf2);
    end
    xin  = v && exp_ready;
    xout = m_valid && ordy;
    if (xout) m_valid = 1'b0;
    if (xin) begin
      frame_q.push_back(d % 4);
      if (l) model_close_frame();
    end
    last_acc = xin;
    @(posedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid4"}, out_valid4, 0);
    check({tag, "_max4"}, out_max4, 0);
    check({tag, "_idx4"}, out_idx4, 0);
    check({tag, "_ovf4"}, out_ovf4, 0);
    check({tag, "_valid2"}, out_valid2, 0);
    check({tag, "_ready4"}, in_ready4, 1);
    check({tag, "_ready2"}, in_ready2, 1);
  endtask

  // Assert reset between clock edges, check it takes effect at once, then
  // release it on a falling edge.
  task automatic mid_reset(input string tag);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int tgt;
    int cnt;
    bit v;
    bit l;
    int d;
    bit o;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1,3,2
    dc(1, 1, 0, 1); dc(1, 3, 0, 1); dc(1, 2, 1, 1);
    #1;
    check("f132_valid", out_valid4, 1);
    check("f132_max", out_max4, 3);
    check("f132_idx", out_idx4, 1);
    check("f132_ovf", out_ovf4, 0);
    dc(0, 0, 0, 1);

    // Frame 2,3,3,1: on the tie the first index is kept
    dc(1, 2, 0, 1); dc(1, 3, 0, 1); dc(1, 3, 0, 1); dc(1, 1, 1, 1);
    #1;
    check("tie_max", out_max4, 3);
    check("tie_idx", out_idx4, 1);
    dc(0, 0, 0, 1);

    // Single beat 0 held for 5 cycles. The garbage offered meanwhile must be ignored.
    dc(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) dc(1, 3, 1, 0);
    #1;
    check("hold_max", out_max4, 0);
    check("hold_idx", out_idx4, 0);
    check("hold_ready", in_ready4, 0);
    dc(0, 0, 0, 1);
    dc(0, 0, 0, 1);

    // 6 beats 0,0,0,0,0,3: the IW=2 instance wraps
    for (int i = 0; i < 5; i++) dc(1, 0, 0, 1);
    dc(1, 3, 1, 1);
    #1;
    check("wrap_ovf2", out_ovf2, 1);
    check("wrap_max2", out_max2, 3);
    check("wrap_idx2", out_idx2, 1);
    check("wrap_ovf4", out_ovf4, 0);
    check("wrap_idx4", out_idx4, 5);
    dc(0, 0, 0, 1);

    // Exactly 2**IW = 4 beats: no overflow on the IW=2 instance
    dc(1, 1, 0, 1); dc(1, 2, 0, 1); dc(1, 3, 0, 1); dc(1, 0, 1, 1);
    #1;
    check("full_ovf2", out_ovf2, 0);
    check("full_idx2", out_idx2, 2);
    dc(0, 0, 0, 1);

    // Back-to-back single-beat frames with no bubble
    dc(1, 1, 1, 1);
    #1;
    check("b2b_first", out_max4, 1);
    dc(1, 2, 1, 1);
    #1;
    check("b2b_second", out_max4, 2);
    check("b2b_valid", out_valid4, 1);
    dc(0, 0, 0, 1);

    // Reset after 2 beats of a frame, then frame 2,1
    dc(1, 3, 0, 1); dc(1, 1, 0, 1);
    mid_reset("rst_mid");
    dc(1, 2, 0, 1); dc(1, 1, 1, 1);
    #1;
    check("post_rst_max", out_max4, 2);
    check("post_rst_idx", out_idx4, 0);

    // Reset while a result is held clears out_valid asynchronously
    dc(0, 0, 0, 0);
    mid_reset("rst_hold");

    // Randomized frames of 1..20 beats with random valid/ready gaps
    tgt = $urandom_range(1, 20);
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom % 4) != 0;
      d = $urandom % 4;
      l = v ? (cnt + 1 == tgt) : ($urandom % 2 == 1);
      o = ($urandom % 3) != 0;
      dc(v, d, l, o);
      if (last_acc) begin
        if (l) begin
          cnt = 0;
          tgt = $urandom_range(1, 20);
        end else begin
          cnt++;
        end
      end
    end
    dc(0, 0, 0, 1);
    dc(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_stream_max_2b
